// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg: ID->EXE pipeline stage register.
// Provides a valid/ready handshake, flush-to-bubble and a saturating stall counter.
// Optional feature: define ID_EXE_SKID_EN to add a skid entry, which makes
// in_ready a registered signal. Without it the stage is a single entry and
// in_ready depends combinationally on out_ready.
module id_exe_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int FUNC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_wb_en,
    input  logic              in_br_taken,
    input  logic [FUNC_W-1:0] in_exe_cmd,
    input  logic [REG_W-1:0]  in_dest,
    input  logic [REG_W-1:0]  in_src1,
    input  logic [REG_W-1:0]  in_src2,
    input  logic [DATA_W-1:0] in_st_val,
    input  logic [DATA_W-1:0] in_val1,
    input  logic [DATA_W-1:0] in_val2,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_wb_en,
    output logic              out_br_taken,
    output logic [FUNC_W-1:0] out_exe_cmd,
    output logic [REG_W-1:0]  out_dest,
    output logic [REG_W-1:0]  out_src1,
    output logic [REG_W-1:0]  out_src2,
    output logic [DATA_W-1:0] out_st_val,
    output logic [DATA_W-1:0] out_val1,
    output logic [DATA_W-1:0] out_val2,
    output logic [DATA_W-1:0] out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              wb_en;
        logic              br_taken;
        logic [FUNC_W-1:0] exe_cmd;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [DATA_W-1:0] st_val;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] pc;
    } payload_t;

    // A bubble keeps its data fields but must never carry live control bits.
    function automatic payload_t kill_ctrl(input payload_t p);
        payload_t r;
        r           = p;
        r.mem_read  = 1'b0;
        r.mem_write = 1'b0;
        r.wb_en     = 1'b0;
        r.br_taken  = 1'b0;
        r.exe_cmd   = '0;
        return r;
    endfunction

    payload_t         in_pl;
    payload_t         main_q;
    logic             main_valid;
    logic             take_in;
    logic             drain;
    logic [CNT_W-1:0] stall_q;

    assign in_pl = {in_mem_read, in_mem_write, in_wb_en, in_br_taken, in_exe_cmd,
                    in_dest, in_src1, in_src2, in_st_val, in_val1, in_val2, in_pc};

    assign take_in = in_valid && in_ready && !flush;
    assign drain   = main_valid && out_ready;

`ifdef ID_EXE_SKID_EN
    payload_t skid_q;
    logic     skid_valid;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
    assign in_ready = ~skid_valid;

    // Main/skid entry update: flush squashes both, skid refills main on drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: payload registers are reset too so that bubble data fields are never X.
            main_valid <= 1'b0;
            main_q     <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_q     <= kill_ctrl(main_q);
            skid_valid <= 1'b0;
            skid_q     <= kill_ctrl(skid_q);
        end else if (skid_valid) begin
            // in_ready is low here, so no new beat can arrive.
            if (drain) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
                skid_q     <= kill_ctrl(skid_q);
            end
        end else if (take_in) begin
            if (!main_valid || drain) begin
                main_valid <= 1'b1;
                main_q     <= in_pl;
            end else begin
                skid_valid <= 1'b1;
                skid_q     <= in_pl;
            end
        end else if (drain) begin
            main_valid <= 1'b0;
            main_q     <= kill_ctrl(main_q);
        end
    end
`else
    // The stage can take a beat when it is empty or emptying this cycle.
    assign in_ready = !main_valid || out_ready;

    // Main entry update: flush squashes, transfer-in loads, lone drain empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: payload registers are reset too so that bubble data fields are never X.
            main_valid <= 1'b0;
            main_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_q     <= kill_ctrl(main_q);
        end else if (take_in) begin
            main_valid <= 1'b1;
            main_q     <= in_pl;
        end else if (drain) begin
            main_valid <= 1'b0;
            main_q     <= kill_ctrl(main_q);
        end
    end
`endif

    // Count cycles in which EXE back-pressure holds a valid entry; saturate at all-ones.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign out_valid     = main_valid;
    assign out_mem_read  = main_q.mem_read;
    assign out_mem_write = main_q.mem_write;
    assign out_wb_en     = main_q.wb_en;
    assign out_br_taken  = main_q.br_taken;
    assign out_exe_cmd   = main_q.exe_cmd;
    assign out_dest      = main_q.dest;
    assign out_src1      = main_q.src1;
    assign out_src2      = main_q.src2;
    assign out_st_val    = main_q.st_val;
    assign out_val1      = main_q.val1;
    assign out_val2      = main_q.val2;
    assign out_pc        = main_q.pc;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Testbench for id_exe_pipe_reg: directed steps followed by random traffic,
// checked against a queue-based model of the stage. A second instance with a
// 4-bit stall counter shares all inputs to exercise counter saturation.
module tb_id_exe_pipe_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int FUNC_W = 4;
    localparam int CNT_W  = 16;
    localparam int S_CNT  = 4;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              wb_en;
        logic              br_taken;
        logic [FUNC_W-1:0] exe_cmd;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [DATA_W-1:0] st_val;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] pc;
    } pl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, flush, out_ready;
    pl_t  drv;

    // Main instance outputs
    logic              in_ready, out_valid;
    logic              out_mem_read, out_mem_write, out_wb_en, out_br_taken;
    logic [FUNC_W-1:0] out_exe_cmd;
    logic [REG_W-1:0]  out_dest, out_src1, out_src2;
    logic [DATA_W-1:0] out_st_val, out_val1, out_val2, out_pc;
    logic [CNT_W-1:0]  stall_cnt;
    pl_t               obs;

    // Small-counter instance outputs
    logic              s_in_ready, s_out_valid;
    logic              s_mem_read, s_mem_write, s_wb_en, s_br_taken;
    logic [FUNC_W-1:0] s_exe_cmd;
    logic [REG_W-1:0]  s_dest, s_src1, s_src2;
    logic [DATA_W-1:0] s_st_val, s_val1, s_val2, s_pc;
    logic [S_CNT-1:0]  s_stall_cnt;
    pl_t               s_obs;

    assign obs   = {out_mem_read, out_mem_write, out_wb_en, out_br_taken, out_exe_cmd,
                    out_dest, out_src1, out_src2, out_st_val, out_val1, out_val2, out_pc};
    assign s_obs = {s_mem_read, s_mem_write, s_wb_en, s_br_taken, s_exe_cmd,
                    s_dest, s_src1, s_src2, s_st_val, s_val1, s_val2, s_pc};

    id_exe_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_mem_read(drv.mem_read), .in_mem_write(drv.mem_write), .in_wb_en(drv.wb_en),
        .in_br_taken(drv.br_taken), .in_exe_cmd(drv.exe_cmd), .in_dest(drv.dest),
        .in_src1(drv.src1), .in_src2(drv.src2), .in_st_val(drv.st_val), .in_val1(drv.val1),
        .in_val2(drv.val2), .in_pc(drv.pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_wb_en(out_wb_en),
        .out_br_taken(out_br_taken), .out_exe_cmd(out_exe_cmd), .out_dest(out_dest),
        .out_src1(out_src1), .out_src2(out_src2), .out_st_val(out_st_val), .out_val1(out_val1),
        .out_val2(out_val2), .out_pc(out_pc), .stall_cnt(stall_cnt)
    );

    id_exe_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .CNT_W(S_CNT)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .flush(flush),
        .in_mem_read(drv.mem_read), .in_mem_write(drv.mem_write), .in_wb_en(drv.wb_en),
        .in_br_taken(drv.br_taken), .in_exe_cmd(drv.exe_cmd), .in_dest(drv.dest),
        .in_src1(drv.src1), .in_src2(drv.src2), .in_st_val(drv.st_val), .in_val1(drv.val1),
        .in_val2(drv.val2), .in_pc(drv.pc),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_mem_read(s_mem_read), .out_mem_write(s_mem_write), .out_wb_en(s_wb_en),
        .out_br_taken(s_br_taken), .out_exe_cmd(s_exe_cmd), .out_dest(s_dest),
        .out_src1(s_src1), .out_src2(s_src2), .out_st_val(s_st_val), .out_val1(s_val1),
        .out_val2(s_val2), .out_pc(s_pc), .stall_cnt(s_stall_cnt)
    );

    // Reference model: the stage is a FIFO of in-flight instructions; the head is what EXE sees.
    pl_t         q[$];
    int unsigned cnt_model;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready();
`ifdef ID_EXE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    function automatic pl_t rand_pl(input logic [31:0] pc);
        logic [159:0] r;
        pl_t          p;
        r    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        p    = r[150:0];
        p.pc = pc;
        return p;
    endfunction

    function automatic logic [191:0] sat(input int unsigned v, input int unsigned max);
        return (v > max) ? 192'(max) : 192'(v);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, out_valid, q.size() != 0);
        check({tag, ".s_out_valid"}, s_out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check({tag, ".payload"}, obs, q[0]);
            check({tag, ".s_payload"}, s_obs, q[0]);
        end else begin
            check({tag, ".bubble_ctrl"},
                  {out_mem_read, out_mem_write, out_wb_en, out_br_taken, out_exe_cmd}, '0);
            check({tag, ".bubble_no_x"}, $isunknown(obs), 1'b0);
        end
        check({tag, ".stall_cnt"}, stall_cnt, sat(cnt_model, 65535));
        check({tag, ".s_stall_cnt"}, s_stall_cnt, sat(cnt_model, 15));
    endtask

    // One clock: check ready before the edge, advance the model on the edge, check after it.
    task automatic cycle(input string tag);
        logic rdy, take, drain, stall;
        #1;
        rdy = model_ready();
        check({tag, ".in_ready"}, in_ready, rdy);
        check({tag, ".s_in_ready"}, s_in_ready, rdy);
        take  = in_valid && rdy && !flush;
        drain = (q.size() != 0) && out_ready;
        stall = (q.size() != 0) && !out_ready && !flush;
        @(posedge clk);
        if (reset) begin
            q.delete();
            cnt_model = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (stall) cnt_model++;
            if (drain) void'(q.pop_front());
            if (take) q.push_back(drv);
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        pl_t held;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; drv = '0;
        cnt_model = 0;

        // Reset state
        cycle("reset0");
        cycle("reset1");
        check("reset_all_zero", {out_valid, obs, stall_cnt}, '0);
        reset = 1'b0;

        // Stream four beats with EXE always ready
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; drv = rand_pl(32'(i * 4));
            cycle("stream");
            check("stream_pc", out_pc, 32'(i * 4));
        end
        in_valid = 1'b0;
        cycle("stream_idle");
        check("stream_stall_cnt", stall_cnt, 0);

        // Stall hold with pc 0x10 in main, 0x14 offered
        in_valid = 1'b1; drv = rand_pl(32'h10);
        cycle("load10");
        held = obs;
        out_ready = 1'b0; drv = rand_pl(32'h14);
        for (int i = 0; i < 5; i++) begin
            cycle("stall");
            check("stall_hold", obs, held);
        end
        check("stall_cnt5", stall_cnt, 5);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle("release0");
        cycle("release1");

        // Flush of a live entry while a new beat is offered
        drv = rand_pl(32'h18); drv.wb_en = 1'b1; drv.mem_write = 1'b1; drv.exe_cmd = 4'h3;
        in_valid = 1'b1; out_ready = 1'b0;
        cycle("load_flush");
        drv = rand_pl(32'h20); flush = 1'b1;
        cycle("flush");
        check("flush_ctrl", {out_valid, out_wb_en, out_mem_write, out_exe_cmd}, '0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle("post_flush");

        // Flush with both entries occupied (one entry without skid)
        in_valid = 1'b1; out_ready = 1'b0; drv = rand_pl(32'h30);
        cycle("fill_main");
        drv = rand_pl(32'h34);
        cycle("fill_skid");
        in_valid = 1'b0; flush = 1'b1;
        cycle("flush_full");
        check("flush_full_valid", out_valid, 1'b0);
        flush = 1'b0; out_ready = 1'b1;
        cycle("after_flush_full");

        // Reset mid-stall at stall_cnt = 7
        reset = 1'b1;
        cycle("reset2");
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0; drv = rand_pl(32'h40);
        cycle("load40");
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) cycle("stall7");
        check("stall_cnt7", stall_cnt, 7);
        reset = 1'b1;
        cycle("reset_mid_stall");
        check("reset_mid_all_zero", {out_valid, obs, stall_cnt}, '0);
        reset = 1'b0;
        cycle("post_reset");
        check("post_reset_in_ready", in_ready, 1'b1);

        // Counter saturation on the 4-bit instance
        in_valid = 1'b1; drv = rand_pl(32'h50);
        cycle("load50");
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat_small", s_stall_cnt, 15);
        check("sat_big", stall_cnt, 20);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drv       = rand_pl($urandom());
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_exe_pipe_reg.md
# id_exe_pipe_reg

Parametrised ID→EXE pipeline stage register with a valid/ready handshake, flush-to-bubble, and a saturating stall counter. It sits between the decode stage and the ALU/execute stage. It carries the decoded control bits, register indices, operand values, store value and PC. Back-pressure from EXE holds the stage, and a flush from the branch unit turns all in-flight content into bubbles.

## Interface
Parameters:
- DATA_W, 32, width of operand, store-value and PC fields
- REG_W, 5, width of register index fields
- FUNC_W, 4, width of EXE command field
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ID presents a decoded instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  squash all held and incoming content
- in_mem_read, in_mem_write, in_wb_en, in_br_taken  in  1 each  control bits
- in_exe_cmd  in  FUNC_W  ALU command
- in_dest, in_src1, in_src2  in  REG_W each  register indices
- in_st_val, in_val1, in_val2, in_pc  in  DATA_W each  store value, operands, PC
- out_valid  out  1  EXE-side entry valid
- out_ready  in  1  EXE consumes this cycle
- out_* (same set as in_*)  out  same widths  registered payload
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Transfer in: in_valid && in_ready && !flush. Transfer out: out_valid && out_ready.
- Main entry: loads on transfer-in when empty or draining. It holds all fields unchanged while out_valid && !out_ready.
- Bubble: when out_valid=0, out_mem_read, out_mem_write, out_wb_en, out_br_taken and out_exe_cmd are all 0. Data/index fields are don't-care but must not contain X after reset.
- Flush has priority over everything except reset:
  - The main entry and any skid entry are invalidated and their control bits zeroed.
  - The input beat offered in the same cycle is discarded.
- stall_cnt increments by 1 each cycle out_valid && !out_ready && !flush. It saturates at all-ones (no wrap). It clears only on reset.
- Reset: every output register is 0, including out_valid, all out_* fields and stall_cnt. in_ready is 1 from the first cycle after reset deasserts.
- Reset asserted mid-stall or mid-flush yields the reset state on the next edge; the pending payload is lost.

## Timing
- Latency: 1 cycle from transfer-in to out_valid=1 with that payload.
- Throughput: 1 instruction/cycle while out_ready=1.
- Without skid: in_ready = !out_valid || out_ready, combinational from out_ready.
- With skid: in_ready is a register output, equal to !skid_valid. See Configuration.
- Simultaneous transfer-in and transfer-out: the new payload replaces the old on the same edge; out_valid stays 1.
- Simultaneous flush and out_ready=1: the consumed beat counts as delivered; the next cycle has out_valid=0.

## Configuration
- ID_EXE_SKID_EN defined: a second (skid) entry is added.
  - If main is full and out_ready=0 while in_ready=1, the incoming beat goes to skid; next cycle in_ready=0.
  - On the next transfer-out, skid moves to main on the same edge and skid empties.
  - Order is strictly preserved. No combinational path from out_ready to in_ready.
- ID_EXE_SKID_EN undefined:
  - Single entry only; no skid storage is synthesised.
  - in_ready is combinational as above.
  - All other behaviour is identical.

## Test plan
- Reset then stream: after reset, pulse in_valid for 4 cycles (pc=0x0,0x4,0x8,0xC) with out_ready=1 -> out_valid=1 from cycle 1 to 4 with pc in order; stall_cnt=0.
- Stall hold: hold out_ready=0 for 5 cycles with pc=0x10 in main -> out_pc stays 0x10, all out_* stable, stall_cnt=5. Without skid, in_ready=0 throughout. With skid, the first extra beat (pc=0x14) is accepted, then in_ready=0; after release, 0x10 then 0x14 are delivered.
- Flush: main holds wb_en=1, mem_write=1, exe_cmd=0x3; assert flush with in_valid=1 and pc=0x20 -> next cycle out_valid=0, out_wb_en=0, out_mem_write=0, out_exe_cmd=0; pc 0x20 is never output.
- Flush during skid-full (ID_EXE_SKID_EN): both entries valid, assert flush -> next cycle out_valid=0, in_ready=1, and both payloads are lost.
- Counter saturation: CNT_W=4, stall for 20 cycles -> stall_cnt reaches 15 and holds 15.
- Reset mid-stall: with out_valid=1, out_ready=0, stall_cnt=7, assert reset for 1 cycle -> all outputs 0, stall_cnt=0; in_ready=1 the following cycle.
